// File: rtl/svpwm_pkg.sv
// Shared types and constants for the inverse Clarke transform block:
// FSM encoding, the sqrt(3)/2 coefficient and the output saturation helper.
package svpwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SUM  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // sqrt(3)/2 in signed Q1.15
  localparam int K2_Q15 = 28378;

  localparam int SAT_W = 16;
  localparam int SUM_W = 18;
  localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -18'sd32768;

  function automatic logic signed [SAT_W-1:0] sat16(input logic signed [SUM_W-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[SAT_W-1:0];
    if (x < SAT_MIN) return SAT_MIN[SAT_W-1:0];
    return x[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past the last granted channel and
// wraps modulo NCH; the first requesting channel found wins.
module rr_arbiter #(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] last_grant,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] grant_idx
);

  localparam int IW = $clog2(NCH);

  always_comb begin : p_search
    logic found;
    int   idx;
    // NOTE: every output gets a default before the search so no path infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NCH; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/inv_clark_arb.sv
// Inverse Clarke transform (alpha/beta/gamma -> a/b/c) shared by NCH requesters
// through a round-robin arbiter and a single 16x16 multiplier, one job in flight.
module inv_clark_arb #(
  parameter int NCH    = 2,
  parameter int K2_Q15 = svpwm_pkg::K2_Q15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           in_valid,
  output logic [NCH-1:0]           in_ready,
  input  logic [NCH-1:0][15:0]     in_alpha,
  input  logic [NCH-1:0][15:0]     in_beta,
  input  logic [NCH-1:0][15:0]     in_gamma,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic signed [15:0]       out_a,
  output logic signed [15:0]       out_b,
  output logic signed [15:0]       out_c,
  output logic                     busy
);

  import svpwm_pkg::*;

  localparam int IW = $clog2(NCH);
  localparam logic signed [15:0] K2_S = 16'(K2_Q15);

  state_t r_state, w_state_nxt;

  logic [IW-1:0]      r_last, r_ch, w_gidx;
  logic [NCH-1:0]     w_grant;
  logic               w_hs;

  logic signed [15:0] r_alpha, r_beta, r_gamma, r_ha;
  logic signed [16:0] r_kb, w_kb;
  logic signed [31:0] w_prod, w_rnd;
  logic signed [17:0] w_a, w_b, w_c;
  logic signed [15:0] r_a, r_b, r_c;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req        (in_valid),
    .last_grant (r_last),
    .grant      (w_grant),
    .grant_idx  (w_gidx)
  );

  assign w_hs = |(in_valid & in_ready);

  // The only multiplier; it serves whichever channel currently owns the pipeline.
  assign w_prod = r_beta * K2_S;
  assign w_rnd  = w_prod + 32'sd16384;
  assign w_kb   = 17'(w_rnd >>> 15);

  assign w_a = 18'(r_alpha) + 18'(r_gamma);
  assign w_b = 18'(r_gamma) + 18'(r_kb) - 18'(r_ha);
  assign w_c = 18'(r_gamma) - 18'(r_kb) - 18'(r_ha);

  assign out_ch = r_ch;
  assign out_a  = r_a;
  assign out_b  = r_b;
  assign out_c  = r_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = '0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = rst ? '0 : w_grant;
        if (w_hs) w_state_nxt = ST_MUL;
      end
      ST_MUL:  w_state_nxt = ST_SUM;
      ST_SUM:  w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= IW'(NCH - 1);
      r_ch    <= '0;
      r_alpha <= '0;
      r_beta  <= '0;
      r_gamma <= '0;
      r_ha    <= '0;
      r_kb    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      // NOTE: non-blocking so every stage reads the previous cycle's values.
      if (w_hs) begin
        r_alpha <= $signed(in_alpha[w_gidx]);
        r_beta  <= $signed(in_beta[w_gidx]);
        r_gamma <= $signed(in_gamma[w_gidx]);
        r_ch    <= w_gidx;
        r_last  <= w_gidx;
      end
      if (r_state == ST_MUL) begin
        r_ha <= r_alpha >>> 1;
        r_kb <= w_kb;
      end
      if (r_state == ST_SUM) begin
        r_a <= sat16(w_a);
        r_b <= sat16(w_b);
        r_c <= sat16(w_c);
      end
    end
  end

endmodule

// File: tb/tb_inv_clark_arb.sv
// Self-checking bench for inv_clark_arb: directed scenarios plus randomized
// traffic compared against an arithmetic reference model and round-robin model.
module tb_inv_clark_arb;

  localparam int NCH = 2;
  localparam int CW  = $clog2(NCH);
  localparam int K2  = 28378;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [NCH-1:0][15:0]  in_alpha, in_beta, in_gamma;
  logic                  out_valid, out_ready, busy;
  logic [CW-1:0]         out_ch;
  logic signed [15:0]    out_a, out_b, out_c;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last;

  always #5 clk = ~clk;

  inv_clark_arb #(.NCH(NCH), .K2_Q15(K2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_alpha  (in_alpha),
    .in_beta   (in_beta),
    .in_gamma  (in_gamma),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .busy      (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int fdiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int sat(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic ref_model(input int al, input int be, input int ga,
                           output int ea, output int eb, output int ec);
    int kb, ha;
    kb = fdiv(longint'(be) * K2 + 16384, 32768);
    ha = fdiv(al, 2);
    ea = sat(al + ga);
    eb = sat(-ha + kb + ga);
    ec = sat(-ha - kb + ga);
  endtask

  function automatic int rr_pick(input int last, input logic [NCH-1:0] mask);
    for (int off = 1; off <= NCH; off++)
      if (mask[(last + off) % NCH]) return (last + off) % NCH;
    return -1;
  endfunction

  function automatic int rand_s16();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic set_ch(input int ch, input int al, input int be, input int ga);
    in_alpha[ch] = 16'(al);
    in_beta[ch]  = 16'(be);
    in_gamma[ch] = 16'(ga);
  endtask

  // Drive a request mask, wait for a grant, then capture the result at the
  // first out_valid. lat counts falling edges after the handshake edge.
  task automatic send_mask(input logic [NCH-1:0] mask, output logic [NCH-1:0] gnt,
                           output int lat, output logic [CW-1:0] och,
                           output logic signed [15:0] oa, output logic signed [15:0] ob,
                           output logic signed [15:0] oc, output bit to);
    to = 1'b0; gnt = '0; lat = 0; och = '0; oa = '0; ob = '0; oc = '0;
    in_valid = mask;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (|in_ready) break;
      @(posedge clk);
    end
    if (!(|in_ready)) begin
      to = 1'b1;
      in_valid = '0;
      return;
    end
    gnt = in_ready;
    @(posedge clk);
    #1;
    in_valid = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (!out_valid) to = 1'b1;
    och = out_ch; oa = out_a; ob = out_b; oc = out_c;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    for (int ch = 0; ch < NCH; ch++) set_ch(ch, 1000, 2000, 3000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== '0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_ch !== '0) begin n_fail++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
    n_checks++; if ({out_a, out_b, out_c} !== 48'd0) begin n_fail++; $display("FAIL reset_outputs: got %0d %0d %0d expected 0 0 0", out_a, out_b, out_c); end
    @(posedge clk);
    #1;
    in_valid = '0;
    out_ready = 1'b0;
    rst = 1'b0;
    m_last = NCH - 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [NCH-1:0] gnt; int lat; logic [CW-1:0] och;
    logic signed [15:0] oa, ob, oc; bit to;
    set_ch(0, 16384, 0, 0);
    send_mask(NCH'(1), gnt, lat, och, oa, ob, oc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout expected result"); end
    n_checks++; if (gnt !== NCH'(1)) begin n_fail++; $display("FAIL basic_grant: got %b expected %b", gnt, NCH'(1)); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    n_checks++; if (och !== CW'(0)) begin n_fail++; $display("FAIL basic_ch: got %0d expected 0", och); end
    n_checks++; if (oa !== 16'sd16384 || ob !== -16'sd8192 || oc !== -16'sd8192) begin
      n_fail++; $display("FAIL basic_abc: got %0d %0d %0d expected 16384 -8192 -8192", oa, ob, oc); end
    m_last = 0;
    release_out();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_after: got busy=%b valid=%b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_beta();
    logic [NCH-1:0] gnt; int lat; logic [CW-1:0] och;
    logic signed [15:0] oa, ob, oc; bit to;
    set_ch(1, 0, 16384, 0);
    send_mask(NCH'(2), gnt, lat, och, oa, ob, oc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL beta_timeout: got timeout expected result"); end
    n_checks++; if (och !== CW'(1)) begin n_fail++; $display("FAIL beta_ch: got %0d expected 1", och); end
    n_checks++; if (oa !== 16'sd0 || ob !== 16'sd14189 || oc !== -16'sd14189) begin
      n_fail++; $display("FAIL beta_abc: got %0d %0d %0d expected 0 14189 -14189", oa, ob, oc); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL beta_busy_hold: got %b expected 1", busy); end
    m_last = 1;
    release_out();
  endtask

  task automatic test_saturation();
    logic [NCH-1:0] gnt; int lat; logic [CW-1:0] och;
    logic signed [15:0] oa, ob, oc; bit to;
    set_ch(0, -32768, 0, -32768);
    send_mask(NCH'(1), gnt, lat, och, oa, ob, oc, to);
    n_checks++; if (to || oa !== -16'sd32768 || ob !== -16'sd16384 || oc !== -16'sd16384) begin
      n_fail++; $display("FAIL sat_neg: got %0d %0d %0d to=%0d expected -32768 -16384 -16384", oa, ob, oc, to); end
    release_out();
    set_ch(0, 32767, 0, 32767);
    send_mask(NCH'(1), gnt, lat, och, oa, ob, oc, to);
    n_checks++; if (to || oa !== 16'sd32767 || ob !== 16'sd16384 || oc !== 16'sd16384) begin
      n_fail++; $display("FAIL sat_pos: got %0d %0d %0d to=%0d expected 32767 16384 16384", oa, ob, oc, to); end
    m_last = 0;
    release_out();
  endtask

  task automatic test_fairness();
    int al[NCH], be[NCH], ga[NCH], ea[NCH], eb[NCH], ec[NCH];
    int exp_ch, seen, last_cyc;
    for (int ch = 0; ch < NCH; ch++) begin
      al[ch] = rand_s16(); be[ch] = rand_s16(); ga[ch] = rand_s16();
      set_ch(ch, al[ch], be[ch], ga[ch]);
      ref_model(al[ch], be[ch], ga[ch], ea[ch], eb[ch], ec[ch]);
    end
    out_ready = 1'b1;
    in_valid = '1;
    seen = 0;
    last_cyc = -1;
    exp_ch = m_last;
    for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        exp_ch = rr_pick(exp_ch, '1);
        n_checks++; if (out_ch !== CW'(exp_ch)) begin n_fail++; $display("FAIL fair_ch%0d: got %0d expected %0d", seen, out_ch, exp_ch); end
        n_checks++; if (out_a !== 16'(ea[exp_ch]) || out_b !== 16'(eb[exp_ch]) || out_c !== 16'(ec[exp_ch])) begin
          n_fail++; $display("FAIL fair_abc%0d: got %0d %0d %0d expected %0d %0d %0d", seen, out_a, out_b, out_c, ea[exp_ch], eb[exp_ch], ec[exp_ch]); end
        if (last_cyc >= 0) begin
          n_checks++; if (cyc - last_cyc !== 4) begin n_fail++; $display("FAIL fair_spacing%0d: got %0d expected 4", seen, cyc - last_cyc); end
        end
        last_cyc = cyc;
        seen++;
        if (seen == 4) begin
          @(posedge clk);
          #1;
          in_valid = '0;
        end
      end
    end
    n_checks++; if (seen !== 4) begin n_fail++; $display("FAIL fair_count: got %0d expected 4", seen); end
    m_last = exp_ch;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NCH-1:0] gnt; int lat; logic [CW-1:0] och;
    logic signed [15:0] oa, ob, oc; bit to;
    int al, be, ga, ea, eb, ec;
    al = rand_s16(); be = rand_s16(); ga = rand_s16();
    set_ch(1, al, be, ga);
    ref_model(al, be, ga, ea, eb, ec);
    send_mask(NCH'(2), gnt, lat, och, oa, ob, oc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: got timeout expected result"); end
    m_last = 1;
    in_valid = '1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || in_ready !== '0) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%b ready=%b expected 1 0", i, out_valid, in_ready); end
      n_checks++; if (out_ch !== CW'(1) || out_a !== 16'(ea) || out_b !== 16'(eb) || out_c !== 16'(ec)) begin
        n_fail++; $display("FAIL bp_stable%0d: got ch=%0d %0d %0d %0d expected ch=1 %0d %0d %0d", i, out_ch, out_a, out_b, out_c, ea, eb, ec); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_abort();
    logic [NCH-1:0] gnt; int lat; logic [CW-1:0] och;
    logic signed [15:0] oa, ob, oc; bit to;
    int ea, eb, ec;
    int seen_valid;
    @(posedge clk);
    #1;
    set_ch(1, 12345, -2222, 333);
    in_valid = NCH'(2);
    @(posedge clk);
    #1;
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = '1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== '0) begin
      n_fail++; $display("FAIL abort_in_reset: got valid=%b busy=%b ready=%b expected 0 0 0", out_valid, busy, in_ready); end
    @(negedge clk);
    n_checks++; if ({out_a, out_b, out_c} !== 48'd0 || out_ch !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got ch=%0d %0d %0d %0d expected zeros", out_ch, out_a, out_b, out_c); end
    @(posedge clk);
    #1;
    in_valid = '0;
    rst = 1'b0;
    m_last = NCH - 1;
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    n_checks++; if (seen_valid !== 0) begin n_fail++; $display("FAIL abort_no_emit: got %0d valid cycles expected 0", seen_valid); end
    for (int ch = 0; ch < NCH; ch++) set_ch(ch, -1000 * (ch + 1), 7000, 50);
    ref_model(-1000, 7000, 50, ea, eb, ec);
    send_mask('1, gnt, lat, och, oa, ob, oc, to);
    n_checks++; if (to || gnt !== NCH'(1) || och !== CW'(0)) begin
      n_fail++; $display("FAIL abort_next_grant: got gnt=%b ch=%0d to=%0d expected %b 0", gnt, och, to, NCH'(1)); end
    n_checks++; if (oa !== 16'(ea) || ob !== 16'(eb) || oc !== 16'(ec)) begin
      n_fail++; $display("FAIL abort_next_abc: got %0d %0d %0d expected %0d %0d %0d", oa, ob, oc, ea, eb, ec); end
    m_last = 0;
    release_out();
  endtask

  task automatic test_random();
    int al[NCH], be[NCH], ga[NCH];
    int w, ea, eb, ec, lat, stall;
    logic [NCH-1:0] mask, gnt, exp_g;
    logic [CW-1:0] och;
    logic signed [15:0] oa, ob, oc;
    bit to;
    for (int it = 0; it < 24; it++) begin
      mask = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int ch = 0; ch < NCH; ch++) begin
        al[ch] = rand_s16(); be[ch] = rand_s16(); ga[ch] = rand_s16();
        set_ch(ch, al[ch], be[ch], ga[ch]);
      end
      w = rr_pick(m_last, mask);
      exp_g = '0;
      exp_g[w] = 1'b1;
      ref_model(al[w], be[w], ga[w], ea, eb, ec);
      send_mask(mask, gnt, lat, och, oa, ob, oc, to);
      n_checks++; if (to || gnt !== exp_g || och !== CW'(w) || lat !== 3) begin
        n_fail++; $display("FAIL rand%0d_arb: got gnt=%b ch=%0d lat=%0d to=%0d expected %b %0d 3", it, gnt, och, lat, to, exp_g, w); end
      n_checks++; if (oa !== 16'(ea) || ob !== 16'(eb) || oc !== 16'(ec)) begin
        n_fail++; $display("FAIL rand%0d_abc: got %0d %0d %0d expected %0d %0d %0d (a=%0d b=%0d g=%0d)", it, oa, ob, oc, ea, eb, ec, al[w], be[w], ga[w]); end
      m_last = w;
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_a !== 16'(ea)) begin
          n_fail++; $display("FAIL rand%0d_stall%0d: got valid=%b a=%0d expected 1 %0d", it, s, out_valid, out_a, ea); end
      end
      release_out();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    in_alpha = '0;
    in_beta = '0;
    in_gamma = '0;
    m_last = NCH - 1;
    test_reset();
    test_basic();
    test_beta();
    test_saturation();
    test_fairness();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_clark_arb.md
INV_CLARK_ARB -- requirements
Module: inv_clark_arb

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requesting channels (2..8).
REQ-002 SHALL have parameter K2_Q15, default 28378, sqrt(3)/2 in signed Q1.15.
REQ-003 SHALL have ports in this order:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  NCH  per-channel request valid
- in_ready  output  NCH  per-channel request accept
- in_alpha  input  NCH x 16 signed  alpha per channel
- in_beta  input  NCH x 16 signed  beta per channel
- in_gamma  input  NCH x 16 signed  zero-sequence per channel
- out_valid  output  1  result valid
- out_ready  input  1  downstream accept
- out_ch  output  clog2(NCH)  channel id of the result
- out_a, out_b, out_c  output  16 signed each  phase results
- busy  output  1  high in any state other than IDLE

Function
REQ-004 SHALL share one 16x16 signed multiplier, time-multiplexed, among all NCH channels.
REQ-005 SHALL implement FSM states IDLE, MUL, SUM and HOLD.
- IDLE->MUL on handshake.
- MUL->SUM unconditionally.
- SUM->HOLD unconditionally.
- HOLD->IDLE when out_ready is high.
REQ-006 SHALL assert in_ready only in IDLE, only for the round-robin winner among the channels whose in_valid is high; in_ready SHALL be combinational from in_valid and the pointer.
REQ-007 SHALL define a handshake as in_valid[i] and in_ready[i] both high at a rising edge; the winner's inputs and channel id SHALL be registered on that edge.
REQ-008 SHALL arbitrate round-robin: search starts at last_grant+1 modulo NCH; last_grant updates on each handshake; last_grant resets to NCH-1 so channel 0 wins first.
REQ-009 SHALL compute the following in MUL:
- kb = (beta*K2_Q15 + 16384) >>> 15 (round half up), kept at 17 bits signed.
- ha = alpha >>> 1 (arithmetic).
REQ-010 SHALL compute the following in SUM at 18-bit signed width:
- a = alpha+gamma
- b = -ha+kb+gamma
- c = -ha-kb+gamma
REQ-011 SHALL saturate each SUM result to [-32768, 32767] and register it into out_a, out_b and out_c.
REQ-012 SHALL assert out_valid exactly in HOLD; the first out_valid cycle SHALL be 3 clocks after the handshake edge.
REQ-013 SHALL hold out_a, out_b, out_c and out_ch stable while out_valid is high and out_ready is low.
REQ-014 SHALL keep in_ready at 0 in MUL, SUM and HOLD; at most one transform SHALL be in flight.
REQ-015 SHALL ensure out_ready high in HOLD returns the FSM to IDLE on that edge; a new handshake is possible the following cycle, giving a sustained throughput of 1 result per 4 cycles.
REQ-016 SHALL ignore out_ready outside HOLD.
REQ-017 SHALL ignore in_valid of non-winning channels; a channel dropping in_valid before grant SHALL lose no state.

Reset
REQ-018 SHALL, while rst is high, force the FSM to IDLE, last_grant to NCH-1, and all data registers to 0.
REQ-019 SHALL hold the following outputs in reset: out_valid=0, out_a=out_b=out_c=0, out_ch=0, busy=0, in_ready=0 (in_ready is gated by rst).
REQ-020 SHALL, on reset asserted mid-transform or in HOLD, discard the in-flight result without emitting it; after release the FSM starts in IDLE.

Structure
REQ-021 SHALL place the FSM state enum, K2_Q15, and the saturation width constants in shared package svpwm_pkg.
REQ-022 SHALL factor the round-robin grant logic into sub-module rr_arbiter (parameter NCH; inputs req and last_grant; outputs one-hot grant and grant index).

Verification
REQ-023 SHALL cover reset: rst=1 with all in_valid=1 -> in_ready=0, out_valid=0, outputs 0, busy=0.
REQ-024 SHALL cover basic transform: ch0 alpha=16384, beta=0, gamma=0 -> 3 cycles later out_valid=1, out_ch=0, a=16384, b=-8192, c=-8192.
REQ-025 SHALL cover the beta path: ch1 alpha=0, beta=16384, gamma=0 -> a=0, b=14189, c=-14189, out_ch=1.
REQ-026 SHALL cover saturation: alpha=-32768, beta=0, gamma=-32768 -> a=-32768 (saturated), b=-16384, c=-16384; alpha=32767, gamma=32767 -> a=32767, b=16384, c=16384.
REQ-027 SHALL cover fairness: all channels continuously valid with out_ready=1 -> out_ch sequence 0,1,0,1 for NCH=2, one result per 4 cycles.
REQ-028 SHALL cover backpressure and reset abort: out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0 throughout; rst pulsed during SUM -> no out_valid, next grant goes to ch0.
